// File: rtl/qr_pkg.sv
// Shared QR definitions for the renderer and the downsampler.
// Define QR_QUIET_ZONE_EN to add a 4-module zero border around the code.
package qr_pkg;

    localparam int unsigned CODE_SIZE     = 21;
    localparam int unsigned CODE_BITS     = CODE_SIZE * CODE_SIZE;
    localparam int unsigned QUIET_MODULES = 4;

`ifdef QR_QUIET_ZONE_EN
    localparam int unsigned BORDER        = QUIET_MODULES;
`else
    localparam int unsigned BORDER        = 0;
`endif
    localparam int unsigned SCAN_MODULES  = CODE_SIZE + 2 * BORDER;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} render_state_t;

    // Code bit for scan module (sx, sy); border modules read as 0.
    function automatic logic code_bit(input logic [CODE_BITS-1:0] code,
                                      input logic [4:0] sx,
                                      input logic [4:0] sy);
        logic [8:0] idx;
`ifdef QR_QUIET_ZONE_EN
        logic [4:0] mx;
        logic [4:0] my;
        if (sx < 5'(QUIET_MODULES) || sx >= 5'(QUIET_MODULES + CODE_SIZE) ||
            sy < 5'(QUIET_MODULES) || sy >= 5'(QUIET_MODULES + CODE_SIZE)) begin
            return 1'b0;
        end
        mx  = sx - 5'(QUIET_MODULES);
        my  = sy - 5'(QUIET_MODULES);
        idx = 9'(my) * 9'(CODE_SIZE) + 9'(mx);
`else
        idx = 9'(sy) * 9'(CODE_SIZE) + 9'(sx);
`endif
        return code[idx];
    endfunction

endpackage

// File: rtl/qr_scan_counter.sv
// One scan axis: pixel coordinate plus module / sub-module counters.
// Wraps back to the start coordinate after the last pixel of the axis.
module qr_scan_counter
    import qr_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               clear_in,
    input  logic               advance_in,
    input  logic [3:0]         module_px_in,
    input  logic signed [11:0] start_in,
    output logic signed [11:0] pos_out,
    output logic [4:0]         module_out,
    output logic               last_out
);

    logic [3:0]         sub_q;
    logic [4:0]         mod_q;
    logic signed [11:0] pos_q;
    logic               sub_last;
    logic               mod_last;

    assign sub_last   = (sub_q == module_px_in - 4'd1);
    assign mod_last   = (mod_q == 5'(SCAN_MODULES - 1));
    assign last_out   = sub_last && mod_last;
    assign pos_out    = pos_q;
    assign module_out = mod_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_q <= '0;
            mod_q <= '0;
            pos_q <= '0;
        end else if (clear_in) begin
            sub_q <= '0;
            mod_q <= '0;
            pos_q <= start_in;
        end else if (advance_in) begin
            if (last_out) begin
                sub_q <= '0;
                mod_q <= '0;
                pos_q <= start_in;
            end else begin
                pos_q <= pos_q + 12'sd1;
                if (sub_last) begin
                    sub_q <= '0;
                    mod_q <= mod_q + 5'd1;
                end else begin
                    sub_q <= sub_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/qr_render_writer.sv
// Renders a latched version-1 QR code into a 1-bit frame buffer, one pixel write per cycle.
// Define QR_QUIET_ZONE_EN to render a 4-module zero border around the code.
module qr_render_writer
    import qr_pkg::*;
#(
    parameter int unsigned WIDTH  = 480,
    parameter int unsigned HEIGHT = 320,
    parameter int unsigned ADDR_W = 20
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [CODE_BITS-1:0] qr_code_in,
    input  logic [3:0]           module_px_in,
    input  logic [10:0]          origin_x_in,
    input  logic [10:0]          origin_y_in,
    input  logic                 wr_ready_in,
    output logic                 wr_en_out,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic                 wr_data_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam logic signed [11:0]     WIDTH_S  = 12'(WIDTH);
    localparam logic signed [11:0]     HEIGHT_S = 12'(HEIGHT);
    localparam logic signed [ADDR_W:0] WIDTH_R  = (ADDR_W + 1)'(WIDTH);

    render_state_t         state_q, state_d;
    logic [CODE_BITS-1:0]  code_q;
    logic [3:0]            m_q;
    logic [10:0]           ox_q, oy_q;
    logic signed [ADDR_W:0] row_base_q;

    logic [11:0]           border_px;
    logic signed [11:0]    x_start, y_start, x_pos, y_pos;
    logic [4:0]            x_mod, y_mod;
    logic                  x_last, y_last;
    logic                  load, in_frame, step;

    // Scan window's top-left pixel, border included.
    assign border_px = 12'(BORDER) * {8'b0, m_q};
    assign x_start   = $signed({1'b0, ox_q}) - $signed(border_px);
    assign y_start   = $signed({1'b0, oy_q}) - $signed(border_px);

    assign load     = (state_q == LOAD);
    assign in_frame = (x_pos >= 12'sd0) && (x_pos < WIDTH_S) &&
                      (y_pos >= 12'sd0) && (y_pos < HEIGHT_S);
    // Off-frame pixels are skipped without waiting for the buffer.
    assign step     = (state_q == WRITE) && (!in_frame || wr_ready_in);

    qr_scan_counter u_x_counter (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clear_in     (load),
        .advance_in   (step),
        .module_px_in (m_q),
        .start_in     (x_start),
        .pos_out      (x_pos),
        .module_out   (x_mod),
        .last_out     (x_last)
    );

    qr_scan_counter u_y_counter (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clear_in     (load),
        .advance_in   (step && x_last),
        .module_px_in (m_q),
        .start_in     (y_start),
        .pos_out      (y_pos),
        .module_out   (y_mod),
        .last_out     (y_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_in) state_d = LOAD;
            LOAD:    state_d = (m_q == 4'd0) ? DONE : WRITE;
            WRITE:   if (step && x_last && y_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            code_q     <= '0;
            m_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_in) begin
                code_q <= qr_code_in;
                m_q    <= module_px_in;
                ox_q   <= origin_x_in;
                oy_q   <= origin_y_in;
            end
            // The only multiply is the one-off first row base.
            if (load) begin
                row_base_q <= (ADDR_W + 1)'(y_start) * WIDTH_R;
            end else if (step && x_last) begin
                row_base_q <= row_base_q + WIDTH_R;
            end
        end
    end

    always_comb begin
        wr_en_out   = (state_q == WRITE) && in_frame;
        wr_addr_out = '0;
        wr_data_out = 1'b0;
        if (wr_en_out) begin
            wr_addr_out = ADDR_W'(row_base_q + (ADDR_W + 1)'(x_pos));
            wr_data_out = code_bit(code_q, x_mod, y_mod);
        end
        busy_out = (state_q == LOAD) || (state_q == WRITE);
        done_out = (state_q == DONE);
    end

endmodule
